// File: rtl/simple_gmii_port.sv
// simple_gmii_port: TV80 I/O-mapped byte port with a TX FIFO feeding a
// GMII-style transmit stream and an RX FIFO filled from the receive stream.
// Handshake: a CPU access is a level (io_select & strobe). A write acts on
// the first edge where it is seen. An RX_DATA read pops on the first edge
// after the read strobe is released.
module simple_gmii_port #(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       io_select,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic [2:0] io_addr,
    input  logic [7:0] io_data_in,
    output logic [7:0] io_data_out,
    output logic [7:0] tx_data,
    output logic       tx_dv,
    output logic       tx_er,
    input  logic [7:0] rx_data,
    input  logic       rx_dv,
    input  logic       rx_er
);
    localparam int CW = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic {TX_IDLE = 1'b0, TX_SEND = 1'b1} tx_state_e;

    logic [7:0] tx_mem_q [2**DEPTH_LOG2];
    logic [7:0] rx_mem_q [2**DEPTH_LOG2];

    tx_state_e             tx_state_q, tx_state_d;
    logic [DEPTH_LOG2-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [CW-1:0]         tx_cnt_q, tx_cnt_d;
    logic                  tx_inject_q, tx_inject_d;
    logic                  tx_dv_q, tx_dv_d, tx_er_q, tx_er_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic [DEPTH_LOG2-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [CW-1:0]         rx_cnt_q, rx_cnt_d;
    logic                  rx_ready_q, rx_ready_d, rx_err_q, rx_err_d;
    logic                  rx_ovf_q, rx_ovf_d, rx_acc_q, rx_acc_d;
    logic                  rx_dv_prev_q, rx_dv_prev_d;
    logic                  wr_prev_q, wr_prev_d, rd_prev_q, rd_prev_d;
    logic                  rd_pend_q, rd_pend_d;

    logic wr_act, rd_act, wr_pulse, ctrl_wr, txd_wr;
    logic tx_busy, tx_full, tx_push, tx_pop, tx_go;
    logic rx_start, rx_ok, rx_push, rx_pop, rx_discard;

    assign wr_act  = io_select & ~wr_n;
    assign rd_act  = io_select & ~rd_n;
    assign tx_busy = (tx_state_q == TX_SEND);
    assign tx_full = (tx_cnt_q == FULL_CNT);

    assign tx_data = tx_data_q;
    assign tx_dv   = tx_dv_q;
    assign tx_er   = tx_er_q;

    function automatic logic [7:0] sat8(input logic [CW-1:0] c);
        return (32'(c) > 32'd255) ? 8'hFF : 8'(c);
    endfunction

    // Next-state logic for the bus front end, TX sender and RX receiver.
    always_comb begin
        tx_state_d   = tx_state_q;
        tx_wptr_d    = tx_wptr_q;
        tx_rptr_d    = tx_rptr_q;
        tx_inject_d  = tx_inject_q;
        tx_dv_d      = 1'b0;
        tx_er_d      = 1'b0;
        tx_data_d    = 8'h00;
        rx_wptr_d    = rx_wptr_q;
        rx_rptr_d    = rx_rptr_q;
        rx_ready_d   = rx_ready_q;
        rx_err_d     = rx_err_q;
        rx_ovf_d     = rx_ovf_q;
        wr_prev_d    = wr_act;
        rd_prev_d    = rd_act;
        rx_dv_prev_d = rx_dv;

        wr_pulse   = wr_act & ~wr_prev_q;
        ctrl_wr    = wr_pulse && (io_addr == 3'd1);
        txd_wr     = wr_pulse && (io_addr == 3'd2);
        tx_push    = txd_wr && !tx_full && !tx_busy;
        tx_pop     = tx_busy && (tx_cnt_q != '0);
        tx_go      = ctrl_wr && io_data_in[0] && (tx_cnt_q != '0) && !tx_busy;
        rx_discard = ctrl_wr && io_data_in[1];

        if (tx_push) tx_wptr_d = tx_wptr_q + DEPTH_LOG2'(1);
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_go) begin
                    tx_state_d  = TX_SEND;
                    tx_inject_d = io_data_in[2];
                end
            end
            TX_SEND: begin
                if (tx_cnt_q != '0) begin
                    tx_dv_d   = 1'b1;
                    tx_er_d   = tx_inject_q;
                    tx_data_d = tx_mem_q[tx_rptr_q];
                    tx_rptr_d = tx_rptr_q + DEPTH_LOG2'(1);
                end else begin
                    tx_state_d  = TX_IDLE;
                    tx_inject_d = 1'b0;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);

        // A pop is armed only if the read saw data, so an empty read never pops.
        rd_pend_d = rd_act ? (rd_pend_q | ((io_addr == 3'd3) && (rx_cnt_q != '0))) : 1'b0;
        rx_pop    = rd_pend_q && !rd_act && (rx_cnt_q != '0);

        rx_start = rx_dv & ~rx_dv_prev_q;
        rx_ok    = rx_start ? ((rx_cnt_q == '0) && !rx_ready_q) : rx_acc_q;
        rx_acc_d = rx_dv & rx_ok;
        rx_push  = rx_dv && rx_ok && ((rx_cnt_q != FULL_CNT) || rx_pop);
        if (rx_start && !rx_ok) rx_ovf_d = 1'b1;
        if (rx_dv && rx_ok && !rx_push) rx_ovf_d = 1'b1;
        if (rx_dv && rx_ok && rx_er) rx_err_d = 1'b1;
        if (rx_push) rx_wptr_d = rx_wptr_q + DEPTH_LOG2'(1);
        if (rx_pop) rx_rptr_d = rx_rptr_q + DEPTH_LOG2'(1);
        rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
        if (!rx_dv && rx_dv_prev_q && rx_acc_q && (rx_cnt_d != '0)) rx_ready_d = 1'b1;
        if (rx_pop && (rx_cnt_d == '0)) begin
            rx_ready_d = 1'b0;
            rx_err_d   = 1'b0;
        end
        if (rx_discard) begin
            rx_wptr_d  = '0;
            rx_rptr_d  = '0;
            rx_cnt_d   = '0;
            rx_ready_d = 1'b0;
            rx_err_d   = 1'b0;
            rx_ovf_d   = 1'b0;
            rx_acc_d   = 1'b0;
            rx_push    = 1'b0;
        end
    end

    // Register read mux; idle bus reads as zero.
    always_comb begin
        io_data_out = 8'h00;
        if (rd_act) begin
            case (io_addr)
                3'd0: io_data_out = {3'b000, tx_full, rx_ovf_q, rx_err_q, tx_busy, rx_ready_q};
                3'd3: io_data_out = (rx_cnt_q != '0) ? rx_mem_q[rx_rptr_q] : 8'h00;
                3'd4: io_data_out = sat8(rx_cnt_q);
                3'd5: io_data_out = sat8(tx_cnt_q);
                default: io_data_out = 8'h00;
            endcase
        end
    end

    // FIFO storage; contents are meaningful only under the counts, so no reset.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wptr_q] <= io_data_in;
        if (rx_push) rx_mem_q[rx_wptr_q] <= rx_data;
    end

    // Control and status state with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_q   <= TX_IDLE;
            tx_wptr_q    <= '0;
            tx_rptr_q    <= '0;
            tx_cnt_q     <= '0;
            tx_inject_q  <= 1'b0;
            tx_dv_q      <= 1'b0;
            tx_er_q      <= 1'b0;
            tx_data_q    <= 8'h00;
            rx_wptr_q    <= '0;
            rx_rptr_q    <= '0;
            rx_cnt_q     <= '0;
            rx_ready_q   <= 1'b0;
            rx_err_q     <= 1'b0;
            rx_ovf_q     <= 1'b0;
            rx_acc_q     <= 1'b0;
            rx_dv_prev_q <= 1'b0;
            wr_prev_q    <= 1'b0;
            rd_prev_q    <= 1'b0;
            rd_pend_q    <= 1'b0;
        end else begin
            tx_state_q   <= tx_state_d;
            tx_wptr_q    <= tx_wptr_d;
            tx_rptr_q    <= tx_rptr_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_inject_q  <= tx_inject_d;
            tx_dv_q      <= tx_dv_d;
            tx_er_q      <= tx_er_d;
            tx_data_q    <= tx_data_d;
            rx_wptr_q    <= rx_wptr_d;
            rx_rptr_q    <= rx_rptr_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_ready_q   <= rx_ready_d;
            rx_err_q     <= rx_err_d;
            rx_ovf_q     <= rx_ovf_d;
            rx_acc_q     <= rx_acc_d;
            rx_dv_prev_q <= rx_dv_prev_d;
            wr_prev_q    <= wr_prev_d;
            rd_prev_q    <= rd_prev_d;
            rd_pend_q    <= rd_pend_d;
        end
    end

    // rd_prev_q is kept as a debug view of the read strobe history.
    logic unused_rd_prev;
    assign unused_rd_prev = rd_prev_q;
endmodule

// File: tb/tb_simple_gmii_port.sv
// Bench for simple_gmii_port: CPU driver tasks, tx monitor, queue-based model.
module tb_simple_gmii_port;
  // ---- clock / reset ----
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  logic       io_select = 1'b0, rd_n = 1'b1, wr_n = 1'b1;
  logic [2:0] io_addr = 3'd0;
  logic [7:0] io_data_in = 8'h00, io_data_out;
  logic [7:0] tx_data, rx_data;
  logic       tx_dv, tx_er, rx_dv, rx_er;
  logic       loop_en = 1'b0;
  logic [7:0] drv_rx_data = 8'h00;
  logic       drv_rx_dv = 1'b0, drv_rx_er = 1'b0;

  assign rx_data = loop_en ? tx_data : drv_rx_data;
  assign rx_dv   = loop_en ? tx_dv   : drv_rx_dv;
  assign rx_er   = loop_en ? tx_er   : drv_rx_er;

  simple_gmii_port #(.DEPTH_LOG2(6)) dut (
    .clk(clk), .reset_n(reset_n), .io_select(io_select), .rd_n(rd_n), .wr_n(wr_n),
    .io_addr(io_addr), .io_data_in(io_data_in), .io_data_out(io_data_out),
    .tx_data(tx_data), .tx_dv(tx_dv), .tx_er(tx_er),
    .rx_data(rx_data), .rx_dv(rx_dv), .rx_er(rx_er)
  );

  // ---- scoreboard state ----
  logic [7:0] exp_q[$];     // expected RX FIFO contents
  logic [7:0] frame_q[$];   // bytes written toward the TX FIFO
  logic [7:0] tx_seen[$];
  int tx_er_cycles = 0, tx_frames = 0, idle_bad = 0;
  logic tx_dv_last = 1'b0, mon_en = 1'b0;
  int n_total = 0, n_bad = 0;

  // tx stream monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      if (tx_dv) begin
        tx_seen.push_back(tx_data);
        if (tx_er) tx_er_cycles++;
        if (!tx_dv_last) tx_frames++;
      end else if (tx_data !== 8'h00 || tx_er !== 1'b0) begin
        idle_bad++;
      end
    end
    tx_dv_last = tx_dv;
  end

  // ---- driver tasks ----
  task automatic io_write(input logic [2:0] a, input logic [7:0] d, input int hold);
    @(negedge clk);
    io_select = 1'b1; wr_n = 1'b0; io_addr = a; io_data_in = d;
    repeat (hold) @(negedge clk);
    io_select = 1'b0; wr_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic io_read(input logic [2:0] a, input int hold, output logic [7:0] d);
    @(negedge clk);
    io_select = 1'b1; rd_n = 1'b0; io_addr = a;
    #1 d = io_data_out;
    repeat (hold) @(negedge clk);
    io_select = 1'b0; rd_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic clear_mon();
    tx_seen.delete(); tx_er_cycles = 0; tx_frames = 0;
  endtask

  // Writes frame_q into TX_DATA then CONTROL=ctrl.
  task automatic send_frame(input logic [7:0] ctrl);
    foreach (frame_q[i]) io_write(3'd2, frame_q[i], 1);
    io_write(3'd1, ctrl, 1);
  endtask

  // ---- tests ----
  task automatic test_reset();
    logic [7:0] d;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_total++; if (tx_dv !== 1'b0) begin n_bad++; $display("FAIL reset_tx_dv got=%b want=0", tx_dv); end
    n_total++; if (tx_er !== 1'b0) begin n_bad++; $display("FAIL reset_tx_er got=%b want=0", tx_er); end
    n_total++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_tx_data got=%h want=00", tx_data); end
    reset_n = 1'b1;
    mon_en = 1'b1;
    io_read(3'd0, 1, d);
    n_total++; if (d !== 8'h00) begin n_bad++; $display("FAIL reset_status got=%h want=00", d); end
    io_read(3'd3, 1, d);
    n_total++; if (d !== 8'h00) begin n_bad++; $display("FAIL reset_rx_data got=%h want=00", d); end
    io_read(3'd4, 1, d);
    n_total++; if (d !== 8'h00) begin n_bad++; $display("FAIL reset_rx_len got=%h want=00", d); end
    io_read(3'd5, 1, d);
    n_total++; if (d !== 8'h00) begin n_bad++; $display("FAIL reset_tx_count got=%h want=00", d); end
  endtask

  task automatic test_loopback();
    logic [7:0] d;
    loop_en = 1'b1;
    clear_mon();
    frame_q = '{8'h11, 8'h22, 8'h33};
    exp_q = frame_q;
    foreach (frame_q[i]) io_write(3'd2, frame_q[i], 1);
    io_read(3'd5, 1, d);
    n_total++; if (d !== 8'd3) begin n_bad++; $display("FAIL lb_tx_count got=%h want=03", d); end
    io_write(3'd1, 8'h01, 1);
    io_read(3'd0, 1, d);
    n_total++; if (d !== 8'h02) begin n_bad++; $display("FAIL lb_busy_status got=%h want=02", d); end
    repeat (8) @(negedge clk);
    n_total++; if (tx_seen.size() != 3) begin n_bad++; $display("FAIL lb_tx_len got=%0d want=3", tx_seen.size()); end
    n_total++; if (tx_frames != 1) begin n_bad++; $display("FAIL lb_tx_frames got=%0d want=1", tx_frames); end
    foreach (tx_seen[i]) begin
      n_total++;
      if (i < frame_q.size() && tx_seen[i] !== frame_q[i]) begin
        n_bad++; $display("FAIL lb_tx_byte%0d got=%h want=%h", i, tx_seen[i], frame_q[i]);
      end
    end
    io_read(3'd0, 1, d);
    n_total++; if (d !== 8'h01) begin n_bad++; $display("FAIL lb_status_ready got=%h want=01", d); end
    io_read(3'd4, 1, d);
    n_total++; if (d !== 8'd3) begin n_bad++; $display("FAIL lb_rx_len got=%h want=03", d); end
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      io_read(3'd3, 1, d);
      n_total++; if (d !== e) begin n_bad++; $display("FAIL lb_rx_byte got=%h want=%h", d, e); end
    end
    io_read(3'd0, 1, d);
    n_total++; if (d !== 8'h00) begin n_bad++; $display("FAIL lb_status_empty got=%h want=00", d); end
  endtask

  task automatic test_strobes();
    logic [7:0] d, a, b;
    loop_en = 1'b1;
    a = 8'($urandom); b = 8'($urandom);
    io_write(3'd2, a, 4);
    io_read(3'd5, 1, d);
    n_total++; if (d !== 8'd1) begin n_bad++; $display("FAIL strobe_tx_count got=%h want=01", d); end
    io_write(3'd2, b, 1);
    io_write(3'd1, 8'h01, 1);
    repeat (6) @(negedge clk);
    io_read(3'd4, 1, d);
    n_total++; if (d !== 8'd2) begin n_bad++; $display("FAIL strobe_rx_len got=%h want=02", d); end
    io_read(3'd3, 4, d);
    n_total++; if (d !== a) begin n_bad++; $display("FAIL strobe_rx_first got=%h want=%h", d, a); end
    io_read(3'd4, 1, d);
    n_total++; if (d !== 8'd1) begin n_bad++; $display("FAIL strobe_one_pop got=%h want=01", d); end
    io_read(3'd3, 1, d);
    n_total++; if (d !== b) begin n_bad++; $display("FAIL strobe_rx_second got=%h want=%h", d, b); end
    io_read(3'd0, 1, d);
    n_total++; if (d !== 8'h00) begin n_bad++; $display("FAIL strobe_status got=%h want=00", d); end
  endtask

  task automatic test_error();
    logic [7:0] d;
    loop_en = 1'b1;
    clear_mon();
    frame_q = '{8'($urandom), 8'($urandom)};
    exp_q = frame_q;
    send_frame(8'h05);
    repeat (6) @(negedge clk);
    n_total++; if (tx_er_cycles != 2) begin n_bad++; $display("FAIL err_tx_er_cycles got=%0d want=2", tx_er_cycles); end
    n_total++; if (tx_seen.size() != 2) begin n_bad++; $display("FAIL err_tx_len got=%0d want=2", tx_seen.size()); end
    io_read(3'd0, 1, d);
    n_total++; if (d !== 8'h05) begin n_bad++; $display("FAIL err_status got=%h want=05", d); end
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      io_read(3'd3, 1, d);
      n_total++; if (d !== e) begin n_bad++; $display("FAIL err_rx_byte got=%h want=%h", d, e); end
    end
    io_read(3'd0, 1, d);
    n_total++; if (d !== 8'h00) begin n_bad++; $display("FAIL err_status_cleared got=%h want=00", d); end
  endtask

  task automatic test_random_frames();
    logic [7:0] d;
    loop_en = 1'b1;
    for (int f = 0; f < 6; f++) begin
      int len;
      len = $urandom_range(1, 48);
      clear_mon();
      frame_q.delete();
      for (int i = 0; i < len; i++) frame_q.push_back(8'($urandom));
      exp_q = frame_q;
      send_frame(8'h01);
      repeat (len + 8) @(negedge clk);
      n_total++; if (tx_seen.size() != len) begin n_bad++; $display("FAIL rnd_tx_len got=%0d want=%0d", tx_seen.size(), len); end
      n_total++; if (tx_er_cycles != 0) begin n_bad++; $display("FAIL rnd_tx_er got=%0d want=0", tx_er_cycles); end
      io_read(3'd4, 1, d);
      n_total++; if (d !== 8'(len)) begin n_bad++; $display("FAIL rnd_rx_len got=%h want=%h", d, 8'(len)); end
      while (exp_q.size() > 0) begin
        logic [7:0] e;
        e = exp_q.pop_front();
        io_read(3'd3, 1, d);
        n_total++; if (d !== e) begin n_bad++; $display("FAIL rnd_rx_byte got=%h want=%h", d, e); end
      end
      io_read(3'd0, 1, d);
      n_total++; if (d !== 8'h00) begin n_bad++; $display("FAIL rnd_status got=%h want=00", d); end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    loop_en = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      drv_rx_dv = 1'b1; drv_rx_data = 8'($urandom);
      if (exp_q.size() < 64) exp_q.push_back(drv_rx_data);
    end
    @(negedge clk); drv_rx_dv = 1'b0;
    repeat (3) @(negedge clk);
    io_read(3'd4, 1, d);
    n_total++; if (d !== 8'd64) begin n_bad++; $display("FAIL ovf_rx_len got=%h want=40", d); end
    io_read(3'd0, 1, d);
    n_total++; if (d !== 8'h09) begin n_bad++; $display("FAIL ovf_status got=%h want=09", d); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drv_rx_dv = 1'b1; drv_rx_data = 8'($urandom);
    end
    @(negedge clk); drv_rx_dv = 1'b0;
    repeat (3) @(negedge clk);
    io_read(3'd4, 1, d);
    n_total++; if (d !== 8'd64) begin n_bad++; $display("FAIL ovf_drop_len got=%h want=40", d); end
    for (int i = 0; i < 3; i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      io_read(3'd3, 1, d);
      n_total++; if (d !== e) begin n_bad++; $display("FAIL ovf_rx_byte got=%h want=%h", d, e); end
    end
    io_read(3'd4, 1, d);
    n_total++; if (d !== 8'd61) begin n_bad++; $display("FAIL ovf_len_after_pop got=%h want=3d", d); end
    io_write(3'd1, 8'h02, 1);
    exp_q.delete();
    io_read(3'd0, 1, d);
    n_total++; if (d !== 8'h00) begin n_bad++; $display("FAIL ovf_discard_status got=%h want=00", d); end
    io_read(3'd4, 1, d);
    n_total++; if (d !== 8'h00) begin n_bad++; $display("FAIL ovf_discard_len got=%h want=00", d); end
  endtask

  task automatic test_tx_full();
    logic [7:0] d, b;
    loop_en = 1'b1;
    clear_mon();
    frame_q.delete();
    for (int i = 0; i < 65; i++) begin
      b = 8'($urandom);
      if (frame_q.size() < 64) frame_q.push_back(b);
      io_write(3'd2, b, 1);
      if (i == 63) begin
        io_read(3'd0, 1, d);
        n_total++; if (d !== 8'h10) begin n_bad++; $display("FAIL full_status got=%h want=10", d); end
      end
    end
    io_read(3'd5, 1, d);
    n_total++; if (d !== 8'd64) begin n_bad++; $display("FAIL full_tx_count got=%h want=40", d); end
    io_write(3'd1, 8'h01, 1);
    repeat (72) @(negedge clk);
    n_total++; if (tx_seen.size() != 64) begin n_bad++; $display("FAIL full_tx_len got=%0d want=64", tx_seen.size()); end
    for (int i = 0; i < 64 && i < tx_seen.size(); i++) begin
      n_total++;
      if (tx_seen[i] !== frame_q[i]) begin n_bad++; $display("FAIL full_tx_byte%0d got=%h want=%h", i, tx_seen[i], frame_q[i]); end
    end
    io_read(3'd4, 1, d);
    n_total++; if (d !== 8'd64) begin n_bad++; $display("FAIL full_rx_len got=%h want=40", d); end
    io_read(3'd0, 1, d);
    n_total++; if (d !== 8'h01) begin n_bad++; $display("FAIL full_rx_status got=%h want=01", d); end
    io_write(3'd1, 8'h02, 1);
    io_read(3'd0, 1, d);
    n_total++; if (d !== 8'h00) begin n_bad++; $display("FAIL full_discard_status got=%h want=00", d); end
  endtask

  task automatic test_start_empty();
    logic [7:0] d;
    loop_en = 1'b1;
    clear_mon();
    io_write(3'd1, 8'h01, 1);
    repeat (6) @(negedge clk);
    n_total++; if (tx_frames != 0) begin n_bad++; $display("FAIL empty_start_frames got=%0d want=0", tx_frames); end
    io_read(3'd0, 1, d);
    n_total++; if (d !== 8'h00) begin n_bad++; $display("FAIL empty_start_status got=%h want=00", d); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    loop_en = 1'b1;
    clear_mon();
    frame_q.delete();
    for (int i = 0; i < 10; i++) frame_q.push_back(8'($urandom));
    send_frame(8'h01);
    repeat (3) @(negedge clk);
    n_total++; if (tx_dv !== 1'b1) begin n_bad++; $display("FAIL mid_tx_active got=%b want=1", tx_dv); end
    reset_n = 1'b0;
    #1;
    n_total++; if (tx_dv !== 1'b0) begin n_bad++; $display("FAIL mid_reset_tx_dv got=%b want=0", tx_dv); end
    n_total++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL mid_reset_tx_data got=%h want=00", tx_data); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    io_read(3'd0, 1, d);
    n_total++; if (d !== 8'h00) begin n_bad++; $display("FAIL mid_status got=%h want=00", d); end
    io_read(3'd4, 1, d);
    n_total++; if (d !== 8'h00) begin n_bad++; $display("FAIL mid_rx_len got=%h want=00", d); end
    io_read(3'd5, 1, d);
    n_total++; if (d !== 8'h00) begin n_bad++; $display("FAIL mid_tx_count got=%h want=00", d); end
  endtask

  // ---- sequence and report ----
  initial begin
    test_reset();
    test_loopback();
    test_strobes();
    test_error();
    test_random_frames();
    test_overflow();
    test_tx_full();
    test_start_empty();
    test_reset_mid_frame();
    n_total++; if (idle_bad != 0) begin n_bad++; $display("FAIL idle_tx_lines got=%0d want=0", idle_bad); end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/simple_gmii_port.md
# simple_gmii_port

Single-clock, byte-wide network port that connects the TV80 I/O bus to a GMII-style transmit/receive byte stream. The CPU fills a transmit FIFO through I/O writes, starts a frame, and reads received frames from a receive FIFO. In the system environment it decodes I/O ports 0x08–0x0F (select supplied externally) and usually runs with tx looped back to rx.

## Interface
Parameters:
- DEPTH_LOG2, default 6 — log2 of TX and RX FIFO depth (64 bytes each).

Ports:
- clk  in  1  — single clock; all logic and both GMII directions are in this domain.
- reset_n  in  1  — asynchronous, active-low reset.
- io_select  in  1  — high when the current I/O access targets this block.
- rd_n  in  1  — active-low read strobe.
- wr_n  in  1  — active-low write strobe.
- io_addr  in  3  — register index.
- io_data_in  in  8  — CPU write data.
- io_data_out  out  8  — register read data.
- tx_data  out  8  — transmit byte.
- tx_dv  out  1  — transmit data valid.
- tx_er  out  1  — transmit error.
- rx_data  in  8  — receive byte.
- rx_dv  in  1  — receive data valid.
- rx_er  in  1  — receive error.

## Operation
- Register map (io_addr):
  - 0 STATUS (R): bit0 rx_ready, bit1 tx_busy, bit2 rx_err, bit3 rx_ovf, bit4 tx_full; bits 7:5 = 0.
  - 1 CONTROL (W): bit0 tx_start; bit1 rx_discard (flush the RX FIFO and clear rx_ready/rx_err); bit2 tx_err_inject (assert tx_er for every byte of the started frame). Reads return 0.
  - 2 TX_DATA (W): push a byte. Ignored if tx_full or tx_busy.
  - 3 RX_DATA (R): head byte of the RX FIFO, popped after the read. Returns 0x00 with no pop if empty.
  - 4 RX_LEN (R): bytes remaining in the RX FIFO, saturating at 255.
  - 5 TX_COUNT (R): bytes in the TX FIFO, saturating at 255.
  - 6–7: read 0x00; writes ignored.
- io_data_out is combinational: selected register when io_select & !rd_n, else 0x00.
- Writes: act once per access, on the first clk edge where io_select & !wr_n is true and was false on the previous edge.
- RX_DATA pop: occurs once per access, on the first edge after io_select & !rd_n deasserts.
- TX: tx_start with TX FIFO non-empty and not tx_busy sends every queued byte in FIFO order, one per cycle, with tx_dv high. The TX FIFO is empty when done. tx_start is ignored if the FIFO is empty or a frame is already sending.
- RX frame: begins on an edge with rx_dv=1 after rx_dv=0.
  - The frame is accepted only if the RX FIFO is empty and rx_ready=0. Otherwise the whole frame is dropped and rx_ovf is set.
  - Each rx_dv cycle pushes rx_data.
  - Any rx_er during the frame sets rx_err.
  - Bytes beyond FIFO capacity are dropped and set rx_ovf.
  - On rx_dv falling, rx_ready=1 if at least one byte was stored.
- Popping the last byte clears rx_ready and rx_err. rx_ovf is sticky and is cleared only by rx_discard or reset.

## Timing
- Reset outputs: tx_dv=0, tx_er=0, tx_data=0x00; both FIFOs empty; all status bits 0.
- tx_start recognised at edge W: tx_busy=1 from W; first byte with tx_dv=1 at edge W+1; N bytes on edges W+1..W+N; tx_dv=0 and tx_busy=0 at edge W+N+1. When tx_dv=0, tx_data=0x00 and tx_er=0.
- RX byte sampled at edge E is visible in RX_LEN after edge E.
- rx_ready rises on the edge where rx_dv is first sampled low.
- Pop and push on the same edge: counts stay consistent, and RX_LEN reflects both.
- Reset mid-frame aborts TX (tx_dv low immediately) and discards all RX state.

## Test plan
- Reset: reset_n=0 → STATUS=0x00, tx_dv=0, RX_DATA reads 0x00.
- Loopback: write 0x11,0x22,0x33 to TX_DATA, write CONTROL=0x01 → tx_dv high exactly 3 cycles carrying 11,22,33; then STATUS=0x01, RX_LEN=3, reads return 11,22,33, STATUS=0x00.
- Multi-cycle strobes: hold wr_n low 4 cycles on TX_DATA → TX_COUNT=1; hold rd_n low 4 cycles on RX_DATA → exactly one pop.
- Error: tx_err_inject (CONTROL=0x05) on a 2-byte frame → tx_er high both cycles; STATUS=0x05 after receipt.
- Overflow: 70-byte rx_dv burst → RX_LEN=64, STATUS bit3 set; second frame while data pending is dropped, RX_LEN unchanged; CONTROL=0x02 → STATUS=0x00.
- Full TX: 64 writes set tx_full (STATUS=0x10); the 65th write is ignored; TX_COUNT=64.
